// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types for the skid buffer stage
package riscv_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    function automatic logic [1:0] skid_occupancy(input skid_state_t s);
        case (s)
            BUSY:    skid_occupancy = 2'd1;
            FULL:    skid_occupancy = 2'd2;
            default: skid_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/register.sv
// rtl/register.sv - clock-enabled data register with asynchronous clear
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (ce_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry valid/ready stage with registered in_ready_o
module pipe_skid_buffer
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            occupancy_o
);

    skid_state_t           state_q;
    skid_state_t           state_d;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_ce;
    logic                  skid_ce;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;

    // Handshake outputs come from state only, keeping out_ready_i off the in_ready_o path.
    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = (state_q != FULL);
    assign occupancy_o = skid_occupancy(state_q);

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_ce = 1'b0;
        skid_ce = 1'b0;
        main_d  = in_data_i;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ce = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ce = 1'b1;
                    end else if (in_fire) begin
                        skid_ce = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    main_d = skid_q;
                    if (out_fire) begin
                        main_ce = 1'b1;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    register #(.WIDTH(DATA_WIDTH)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (main_ce),
        .d_i   (main_d),
        .q_o   (out_data_o)
    );

    register #(.WIDTH(DATA_WIDTH)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (skid_ce),
        .d_i   (in_data_i),
        .q_o   (skid_q)
    );

endmodule
